// File: rtl/serial_adder.sv
// Multi-cycle add/subtract built on one DIGIT-bit adder slice.
// Operands stream LSB first; carry/borrow is held between steps.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inCarry,
  input  logic             inSub,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   full;
  logic [DIGIT-1:0] d;
  logic             c_next;
  logic             c_msb;
  logic [WIDTH-1:0] res_shift;
  logic             last;

  assign a_dig  = opa_q[DIGIT-1:0];
  assign b_dig  = opb_q[DIGIT-1:0];
  assign full   = {1'b0, a_dig} + {1'b0, b_dig}
                + {{DIGIT{1'b0}}, c_q};
  assign d      = full[DIGIT-1:0];
  assign c_next = full[DIGIT];
  // sum bit = a ^ b ^ cin, so cin into the top bit is recoverable
  assign c_msb  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ d[DIGIT-1];
  assign last   = (cnt_q == '0);

  assign res_shift = (res_q >> DIGIT)
                   | (WIDTH'(d) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (inValid) begin
          opa_d   = inA;
          opb_d   = inSub ? ~inB : inB;
          c_d     = inSub ^ inCarry;
          sub_d   = inSub;
          cnt_d   = CW'(STEPS - 1);
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d = opa_q >> DIGIT;
        opb_d = opb_q >> DIGIT;
        res_d = res_shift;
        c_d   = c_next;
        if (last) begin
          sum_d   = res_shift;
          carry_d = sub_q ^ c_next;
          ovf_d   = c_msb ^ c_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign inReady  = (state_q == IDLE);
  assign outValid = (state_q == DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder, bit-serial and 4-bit-digit builds.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;

  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] inA = '0;
  logic [15:0] inB = '0;
  logic        inCarry = 1'b0;
  logic        inSub = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] sum;
  logic        carry;
  logic        overflow;

  logic        inValid4 = 1'b0;
  logic        inReady4;
  logic [15:0] inA4 = '0;
  logic [15:0] inB4 = '0;
  logic        inCarry4 = 1'b0;
  logic        inSub4 = 1'b0;
  logic        outValid4;
  logic        outReady4 = 1'b0;
  logic [15:0] sum4;
  logic        carry4;
  logic        overflow4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(1)) dut (
    .clk(clk), .rstN(rstN),
    .inValid(inValid), .inReady(inReady),
    .inA(inA), .inB(inB),
    .inCarry(inCarry), .inSub(inSub),
    .outValid(outValid), .outReady(outReady),
    .sum(sum), .carry(carry), .overflow(overflow)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rstN(rstN),
    .inValid(inValid4), .inReady(inReady4),
    .inA(inA4), .inB(inB4),
    .inCarry(inCarry4), .inSub(inSub4),
    .outValid(outValid4), .outReady(outReady4),
    .sum(sum4), .carry(carry4), .overflow(overflow4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic ci,
                        input logic sb,
                        input logic [15:0] es,
                        input logic ec,
                        input logic eo);
    int k;
    @(negedge clk);
    chk({tag, "_rdy"}, inReady, 1);
    inValid = 1'b1;
    inA = a;
    inB = b;
    inCarry = ci;
    inSub = sb;
    @(negedge clk);
    inValid = 1'b0;
    k = 0;
    while (!outValid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, k, 16);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_c"}, carry, ec);
    chk({tag, "_ov"}, overflow, eo);
  endtask

  task automatic retire(input string tag);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    chk({tag, "_ovld"}, outValid, 0);
    chk({tag, "_irdy"}, inReady, 1);
  endtask

  initial begin
    int k;
    int t[$];

    #1;
    chk("rst_irdy", inReady, 1);
    chk("rst_ovld", outValid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c", carry, 0);
    chk("rst_ov", overflow, 0);
    chk("rst_ovld4", outValid4, 0);
    #20 rstN = 1'b1;

    run_op("add1", 16'h00FF, 16'h0001, 0, 0,
           16'h0100, 0, 0);
    retire("add1");
    run_op("addc", 16'hFFFF, 16'h0001, 0, 0,
           16'h0000, 1, 0);
    retire("addc");
    run_op("addv", 16'h7FFF, 16'h0001, 0, 0,
           16'h8000, 0, 1);
    retire("addv");
    run_op("addci", 16'h0010, 16'h0020, 1, 0,
           16'h0031, 0, 0);
    retire("addci");
    run_op("sub1", 16'h0005, 16'h0007, 0, 1,
           16'hFFFE, 1, 0);
    retire("sub1");
    run_op("subbi", 16'h0009, 16'h0003, 1, 1,
           16'h0005, 0, 0);
    retire("subbi");
    run_op("subv", 16'h8000, 16'h0001, 0, 1,
           16'h7FFF, 0, 1);

    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      inA = 16'h0101;
      inB = 16'h0202;
      @(negedge clk);
      chk("bp_ovld", outValid, 1);
      chk("bp_irdy", inReady, 0);
      chk("bp_sum", sum, 16'h7FFF);
      chk("bp_c", carry, 0);
      chk("bp_ov", overflow, 1);
    end
    inValid = 1'b0;
    retire("bp");
    chk("bp_keep", sum, 16'h7FFF);

    @(negedge clk);
    inValid = 1'b1;
    inA = 16'hAAAA;
    inB = 16'h1111;
    inSub = 1'b0;
    inCarry = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    repeat (7) @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("mr_sum", sum, 0);
    chk("mr_c", carry, 0);
    chk("mr_ov", overflow, 0);
    chk("mr_ovld", outValid, 0);
    chk("mr_irdy", inReady, 1);
    @(negedge clk);
    rstN = 1'b1;
    run_op("post", 16'h1234, 16'h1111, 0, 0,
           16'h2345, 0, 0);
    retire("post");

    @(negedge clk);
    chk("d4_rdy", inReady4, 1);
    inValid4 = 1'b1;
    inA4 = 16'hFFFF;
    inB4 = 16'h0000;
    inCarry4 = 1'b1;
    @(negedge clk);
    inValid4 = 1'b0;
    inCarry4 = 1'b0;
    k = 0;
    while (!outValid4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("d4_lat", k, 4);
    chk("d4_sum", sum4, 16'h0000);
    chk("d4_c", carry4, 1);
    chk("d4_ov", overflow4, 0);
    outReady4 = 1'b1;
    @(negedge clk);
    chk("d4_ret", outValid4, 0);

    inValid4 = 1'b1;
    inA4 = 16'h0001;
    inB4 = 16'h0002;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (outValid4) begin
        t.push_back(c);
        chk("b2b_sum", sum4, 16'h0003);
      end
    end
    inValid4 = 1'b0;
    outReady4 = 1'b0;
    chk("b2b_cnt_ok", (t.size() >= 3), 1);
    if (t.size() >= 3) begin
      chk("b2b_gap0", t[1] - t[0], 6);
      chk("b2b_gap1", t[2] - t[1], 6);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Built around a single DIGIT-bit full-adder slice that is reused across cycles.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, LSB first. Carry/borrow is held in a register between steps.
- Next generation of the combinational full-adder cell: word width, per-cycle digit width, subtract mode, overflow flag and valid/ready handshakes.
- Sits between the register file and the ALU result mux as the area-cheap arithmetic path.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 1: bits processed per clock. Must be ≥ 1 and divide WIDTH.
- STEPS (localparam): WIDTH/DIGIT, the number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- inValid  input  1  request: operands are valid
- inReady  output  1  block can accept a request
- inA  input  WIDTH  operand A
- inB  input  WIDTH  operand B
- inCarry  input  1  carry-in (add) / borrow-in (sub)
- inSub  input  1  0: A+B+carry; 1: A-B-borrow
- outValid  output  1  result valid
- outReady  input  1  consumer accepts result
- sum  output  WIDTH  result
- carry  output  1  carry-out (add) / borrow-out (sub)
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. rstN is asynchronous and active-low. Assertion immediately forces:
  - state IDLE
  - sum=0, carry=0, overflow=0, outValid=0
  - step counter=0 and all internal shift registers=0
  - inReady=1 once in IDLE (inReady is decoded from state)
- Reset during RUN or DONE aborts the operation. No result is produced.
- State IDLE:
  - inReady=1, outValid=0.
  - On an edge with inValid=1, capture opA=inA and opB = inSub ? ~inB : inB.
  - Capture the carry register c = inSub ? ~inCarry : inCarry, and the captured sub flag.
  - Load counter=STEPS-1 and go to RUN. Requests while not in IDLE are ignored; inReady=0 there.
- State RUN, one DIGIT-bit step per cycle:
  - {cNext, d} = opA[DIGIT-1:0] + opB[DIGIT-1:0] + c.
  - opA and opB shift right by DIGIT. d shifts into the result register from the MSB end, so after STEPS steps bit 0 is in sum[0].
  - c <= cNext.
  - On the step where counter==0, also compute the carry into the MSB (bit WIDTH-1) inside the digit; overflow = carryIntoMsb ^ cNext.
  - Go to DONE after that step; otherwise decrement counter.
- State DONE:
  - outValid=1. sum, carry and overflow hold stable for as long as outValid is high.
  - carry = sub ? ~cFinal : cFinal, i.e. borrow-out for subtract.
  - On an edge with outValid&outReady, go to IDLE.
  - sum, carry and overflow keep their last values after leaving DONE and are only meaningful while outValid=1.
- Latency: request accepted at edge t gives outValid=1 after edge t+STEPS. Throughput is one operation per STEPS+2 cycles with outReady held high.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Subtract is A + ~B + ~borrowIn.
  - The overflow rule is the same for add and subtract.
- Boundary cases:
  - DIGIT==WIDTH: single RUN cycle (STEPS=1).
  - outReady held high in DONE: exactly one-cycle outValid pulse.
  - inValid held high through the return to IDLE: the next request is accepted on the first IDLE edge.

Test Plan:
- WIDTH=16, DIGIT=1, add 0x00FF+0x0001, carry-in 0 -> after exactly 16 RUN cycles: sum=0x0100, carry=0, overflow=0.
- Add 0xFFFF+0x0001 -> sum=0x0000, carry=1, overflow=0. Add 0x7FFF+0x0001 -> sum=0x8000, carry=0, overflow=1.
- Subtract 0x0005-0x0007, borrow-in 0 -> sum=0xFFFE, carry(borrow)=1, overflow=0. Subtract 0x8000-0x0001 -> sum=0x7FFF, borrow=0, overflow=1.
- Back-pressure: hold outReady=0 for 5 cycles in DONE -> outValid, sum, carry and overflow are stable every cycle, and inReady=0 with inValid=1 is not accepted. Raise outReady -> IDLE next edge, inReady=1.
- Reset mid-RUN, at step 7 of 16 -> outputs zero immediately, no outValid. A new request 0x1234+0x1111 then completes with sum=0x2345.
- DIGIT=4 build: 0xFFFF+0x0000 with carry-in 1 -> outValid after 4 cycles, sum=0x0000, carry=1. Back-to-back requests with outReady=1 -> one result every 6 cycles.
